// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS-subset main controller.
// Sequences FETCH/DECODE/EXECUTE/MEM/WB, drives the ALU op code and the datapath
// mux selects and write enables, resolves branches from alu_equal and raises
// illegal-instruction and arithmetic-overflow traps.
module multicycle_control_fsm #(
    parameter bit         EXC_ENABLE     = 1'b1,
    parameter logic [1:0] EXC_VECTOR_SEL = 2'b11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       alu_equal,
    input  logic       alu_overflow,
    output logic [2:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_write,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       exception,
    output logic [1:0] exc_cause,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPE_EX = 4'd6,
        RTYPE_WB = 4'd7,
        IMM_EX   = 4'd8,
        IMM_WB   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        EXC      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
    localparam logic [1:0] CAUSE_OVERFLOW = 2'b10;

    state_t     state_reg, state_next;
    logic [1:0] exc_cause_reg, exc_cause_next;
    logic [2:0] rtype_op;
    logic       funct_legal;
    logic [2:0] imm_op;

    // The zero flag plays no part in branch resolution (alu_equal is used).
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;

    // R-type funct to ALU op; anything outside the table is an illegal instruction.
    always_comb begin
        funct_legal = 1'b1;
        rtype_op    = 3'b001;
        case (funct)
            6'b100100: rtype_op = 3'b000;
            6'b100000: rtype_op = 3'b001;
            6'b100010: rtype_op = 3'b010;
            6'b101010: rtype_op = 3'b011;
            6'b000010: rtype_op = 3'b100;
            6'b000011: rtype_op = 3'b101;
            6'b000000: rtype_op = 3'b110;
            default:   funct_legal = 1'b0;
        endcase
    end

    // Immediate opcode to ALU op.
    always_comb begin
        imm_op = 3'b001;
        case (opcode)
            OP_ANDI: imm_op = 3'b000;
            OP_SLTI: imm_op = 3'b011;
            default: imm_op = 3'b001;
        endcase
    end

    // State and trap-cause registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= FETCH;
            exc_cause_reg <= 2'b00;
        end else begin
            state_reg     <= state_next;
            exc_cause_reg <= exc_cause_next;
        end
    end

    // Next-state logic and Moore output decode (pc_write in BRANCH follows alu_equal).
    always_comb begin
        state_next     = state_reg;
        exc_cause_next = exc_cause_reg;
        alu_op         = 3'b001;
        alu_src_a      = 1'b0;
        alu_src_b      = 2'b00;
        pc_src         = 2'b00;
        pc_write       = 1'b0;
        ir_write       = 1'b0;
        iord           = 1'b0;
        mem_write      = 1'b0;
        reg_write      = 1'b0;
        reg_dst        = 1'b0;
        mem_to_reg     = 1'b0;
        exception      = 1'b0;
        case (state_reg)
            FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = 2'b01;
                state_next = DECODE;
            end
            DECODE: begin
                // Branch target is computed speculatively into ALUOut.
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:              state_next = MEMADR;
                    OP_ADDI, OP_ANDI, OP_SLTI: state_next = IMM_EX;
                    OP_BEQ, OP_BNE:            state_next = BRANCH;
                    OP_J:                      state_next = JUMP;
                    default: begin
                        if (opcode == OP_RTYPE && funct_legal) begin
                            state_next = RTYPE_EX;
                        end else if (EXC_ENABLE) begin
                            state_next     = EXC;
                            exc_cause_next = CAUSE_ILLEGAL;
                        end else begin
                            state_next = FETCH;
                        end
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord       = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_next = FETCH;
            end
            MEMWR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                state_next = FETCH;
            end
            RTYPE_EX: begin
                alu_src_a = 1'b1;
                alu_op    = rtype_op;
                if (EXC_ENABLE && alu_overflow && (rtype_op == 3'b001 || rtype_op == 3'b010)) begin
                    state_next     = EXC;
                    exc_cause_next = CAUSE_OVERFLOW;
                end else begin
                    state_next = RTYPE_WB;
                end
            end
            RTYPE_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                state_next = FETCH;
            end
            IMM_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = imm_op;
                if (EXC_ENABLE && alu_overflow && opcode == OP_ADDI) begin
                    state_next     = EXC;
                    exc_cause_next = CAUSE_OVERFLOW;
                end else begin
                    state_next = IMM_WB;
                end
            end
            IMM_WB: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 3'b010;
                pc_src     = 2'b01;
                pc_write   = (opcode == OP_BNE) ? !alu_equal : alu_equal;
                state_next = FETCH;
            end
            JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                state_next = FETCH;
            end
            EXC: begin
                exception  = 1'b1;
                pc_write   = 1'b1;
                pc_src     = EXC_VECTOR_SEL;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    assign exc_cause = exc_cause_reg;
    assign state_dbg = state_reg;

endmodule
